// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: sequential reads, prefetch FIFO, redirect flush. IF_PERF_CNT_EN adds fetch_cnt/flush_cnt.
// Latency: issue to if_valid takes 2 cycles; redirect to if_valid takes 3 cycles.
// Backpressure: id_ready low holds the head; issue stops once buffered plus in-flight words reach FIFO_DEPTH.
module if_prefetch_unit #(
   parameter int                   WORD_SIZE  = 16,
   parameter int                   FIFO_DEPTH = 4,
   parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic                 i_readM,
   output logic                 i_writeM,
   output logic [WORD_SIZE-1:0] i_address,
   inout  wire  [WORD_SIZE-1:0] i_data,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   input  logic                 halt,
   input  logic                 id_ready,
   output logic                 if_valid,
   output logic [WORD_SIZE-1:0] if_instr,
   output logic [WORD_SIZE-1:0] if_pc
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0]          fetch_cnt,
   output logic [15:0]          flush_cnt
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [WORD_SIZE-1:0] pc;
      logic [WORD_SIZE-1:0] instr;
   } entry_t;

   entry_t               fifo_mem [FIFO_DEPTH];
   entry_t               head;
   logic [PW-1:0]        rd_ptr, wr_ptr;
   logic [PW:0]          count;
   logic [WORD_SIZE-1:0] fetch_pc, resp_pc;
   logic                 resp_pending, resp_squash;
   logic [PW+1:0]        credit_used;
   logic                 issue, push, pop;

   // In-flight reads hold a slot, so a response always has room to land.
   assign credit_used = {1'b0, count} + (PW+2)'(resp_pending);
   assign issue       = reset_n && !redirect && !halt && (credit_used < (PW+2)'(FIFO_DEPTH));
   assign push        = resp_pending && !resp_squash && !redirect;
   assign pop         = if_valid && id_ready && !redirect;

   assign i_readM   = issue || resp_pending;
   assign i_writeM  = 1'b0;
   assign i_address = fetch_pc;

   assign head     = fifo_mem[rd_ptr];
   assign if_valid = (count != '0);
   assign if_instr = if_valid ? head.instr : '0;
   assign if_pc    = if_valid ? head.pc    : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= entry_t'{pc: resp_pc, instr: i_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc     <= RESET_PC;
         resp_pc      <= '0;
         resp_pending <= 1'b0;
         resp_squash  <= 1'b0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
      end else begin
         resp_pending <= issue;
         resp_squash  <= redirect;
         if (issue) begin
            resp_pc <= fetch_pc;
         end
         if (redirect) begin
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + WORD_SIZE'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pop && fetch_cnt != 16'hFFFF) begin
            fetch_cnt <= fetch_cnt + 16'd1;
         end
         if (redirect && flush_cnt != 16'hFFFF) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed cycle checks plus a randomized run scored
// against the sequential-program-stream model (pc, mem[pc]) restarted on redirect/reset.
module tb_if_prefetch_unit;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         redirect = 1'b0, halt = 1'b0, id_ready = 1'b0;
   logic [W-1:0] redirect_pc = '0;
   logic         i_readM, i_writeM, if_valid;
   logic [W-1:0] i_address, if_instr, if_pc;
   wire  [W-1:0] i_data;

   logic [W-1:0] mem [0:65535];
   logic [W-1:0] mem_q = '0;

   typedef struct packed {
      logic [W-1:0] pc;
      logic [W-1:0] instr;
   } exp_t;
   exp_t         exp_q[$];
   logic [W-1:0] model_pc = '0;
   int           checks = 0;
   int           errors = 0;

   if_prefetch_unit #(.WORD_SIZE(16), .FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address), .i_data(i_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .id_ready(id_ready),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
   );

   always #5 clk = ~clk;

   // Memory: registered read; drives the bus only while i_readM is high.
   always @(posedge clk) if (i_readM) mem_q <= mem[i_address];
   assign i_data = i_readM ? mem_q : 16'h0BAD;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic topup();
      while (exp_q.size() < 32) begin
         exp_q.push_back(exp_t'{pc: model_pc, instr: mem[model_pc]});
         model_pc = model_pc + 16'd1;
      end
   endtask

   task automatic restart(input logic [W-1:0] pc);
      exp_q.delete();
      model_pc = pc;
      topup();
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      topup();
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      redirect = 1'b0;
      halt     = 1'b0;
      exp_q.delete();
      cyc();
      cyc();
   endtask

   task automatic release_reset();
      reset_n = 1'b1;
      restart(16'h0000);
   endtask

   // Scoreboard monitor: every accepted head entry must be the next word of the stream.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && !if_valid) begin
         checks++;
         if (if_pc !== '0 || if_instr !== '0) begin
            errors++;
            $display("FAIL idle_zero: got pc=%h instr=%h, expected 0/0", if_pc, if_instr);
         end
      end
      if (reset_n && if_valid && id_ready && !redirect) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got pc=%h with no expected entry", if_pc);
         end else begin
            e = exp_q.pop_front();
            if (if_pc !== e.pc || if_instr !== e.instr) begin
               errors++;
               $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                        if_pc, if_instr, e.pc, e.instr);
            end
         end
      end
   end

   initial begin
      logic seen;
      for (int i = 0; i < 65536; i++) mem[i] = W'($urandom);
      mem[0]     = 16'h9023;
      mem[16'h23] = 16'h6000;

      // Reset state and first fetch timing
      id_ready = 1'b1;
      do_reset();
      check("rst_readM", i_readM, 0);
      check("rst_addr", i_address, 0);
      check("rst_valid", if_valid, 0);
      check("rst_instr", if_instr, 0);
      check("rst_pc", if_pc, 0);
      release_reset();
      #1;
      check("c0_readM", i_readM, 1);
      check("c0_addr", i_address, 0);
      cyc();
      check("c1_valid", if_valid, 0);
      check("c1_addr", i_address, 1);
      cyc();
      check("c2_valid", if_valid, 1);
      check("c2_pc", if_pc, 0);
      check("c2_instr", if_instr, 16'h9023);
      for (int k = 1; k <= 3; k++) begin
         cyc();
         check("seq_valid", if_valid, 1);
         check("seq_pc", if_pc, k);
      end

      // Fill with decode stalled, then drain
      id_ready = 1'b0;
      do_reset();
      release_reset();
      repeat (8) cyc();
      check("full_readM", i_readM, 0);
      check("full_addr", i_address, 4);
      check("full_valid", if_valid, 1);
      check("full_head", if_pc, 0);
      id_ready = 1'b1;
      #1;
      for (int k = 0; k <= 4; k++) begin
         check("drain_valid", if_valid, 1);
         check("drain_pc", if_pc, k);
         cyc();
      end

      // Redirect with a response pending and two entries buffered
      id_ready = 1'b0;
      do_reset();
      release_reset();
      cyc(); cyc(); cyc();
      check("pre_redir_valid", if_valid, 1);
      redirect    = 1'b1;
      redirect_pc = 16'h0023;
      restart(16'h0023);
      #1;
      check("redir_readM", i_readM, 1);
      cyc();
      redirect = 1'b0;
      id_ready = 1'b1;
      #1;
      check("redir1_valid", if_valid, 0);
      check("redir1_addr", i_address, 16'h0023);
      check("redir1_readM", i_readM, 1);
      cyc();
      check("redir2_valid", if_valid, 0);
      cyc();
      check("redir3_valid", if_valid, 1);
      check("redir3_pc", if_pc, 16'h0023);
      check("redir3_instr", if_instr, 16'h6000);

      // Redirect across the address wrap
      cyc();
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      restart(16'hFFFF);
      cyc();
      redirect = 1'b0;
      cyc(); cyc();
      check("wrap_pc0", if_pc, 16'hFFFF);
      check("wrap_instr0", if_instr, mem[16'hFFFF]);
      cyc();
      check("wrap_pc1", if_pc, 16'h0000);
      cyc();
      check("wrap_pc2", if_pc, 16'h0001);

      // Halt with one request in flight
      id_ready = 1'b1;
      do_reset();
      release_reset();
      cyc();
      halt = 1'b1;
      #1;
      check("halt_resp_readM", i_readM, 1);
      check("halt_addr", i_address, 1);
      cyc();
      check("halt_push_valid", if_valid, 1);
      check("halt_push_pc", if_pc, 0);
      check("halt_idle_readM", i_readM, 0);
      repeat (4) cyc();
      check("halt_hold_addr", i_address, 1);
      check("halt_hold_valid", if_valid, 0);
      halt = 1'b0;
      #1;
      check("resume_readM", i_readM, 1);
      check("resume_addr", i_address, 1);
      cyc(); cyc();
      check("resume_pc", if_pc, 1);

      // Reset mid-stream with FIFO full
      id_ready = 1'b0;
      do_reset();
      release_reset();
      repeat (8) cyc();
      check("midrst_full", if_valid, 1);
      reset_n = 1'b0;
      exp_q.delete();
      cyc();
      check("midrst_valid", if_valid, 0);
      check("midrst_readM", i_readM, 0);
      check("midrst_addr", i_address, 0);
      release_reset();
      #1;
      check("restart_addr", i_address, 0);
      check("restart_readM", i_readM, 1);
      id_ready = 1'b1;
      cyc(); cyc();
      check("restart_pc", if_pc, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if (!reset_n) begin
            release_reset();
            redirect = 1'b0;
         end else if ($urandom_range(0, 499) == 0) begin
            reset_n  = 1'b0;
            redirect = 1'b0;
            exp_q.delete();
         end else begin
            id_ready = ($urandom_range(0, 3) != 0);
            halt     = ($urandom_range(0, 7) == 0);
            redirect = ($urandom_range(0, 24) == 0);
            if (redirect) begin
               redirect_pc = ($urandom_range(0, 1) == 0) ? W'($urandom)
                                                          : W'(16'hFFF8 + W'($urandom_range(0, 7)));
               restart(redirect_pc);
            end
         end
      end

      // Liveness: with everything released, data must flow again
      cyc();
      if (!reset_n) release_reset();
      redirect = 1'b0;
      halt     = 1'b0;
      id_ready = 1'b1;
      seen     = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         cyc();
         if (if_valid) seen = 1'b1;
      end
      check("final_live", seen, 1);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch stage placed between the unified Memory instruction port (i_readM/i_address/i_data) and the decode stage.
- Holds the fetch PC and issues sequential instruction reads against the 1-cycle registered memory read.
- Buffers returned words with their PCs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush, and a halt input.

Parameters:
- WORD_SIZE, 16, instruction/address width.
- FIFO_DEPTH, 4, prefetch entries; power of two, 2..16.
- RESET_PC, 16'h0000, PC fetched first after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- i_readM  out  1  memory read request; must also be high during the response cycle so Memory drives i_data.
- i_writeM  out  1  tied 0.
- i_address  out  WORD_SIZE  fetch address.
- i_data  inout  WORD_SIZE  instruction bus; never driven by this block (always z).
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  WORD_SIZE  new fetch PC.
- halt  in  1  suppress new issues.
- id_ready  in  1  decode accepts head entry.
- if_valid  out  1  head entry valid.
- if_instr  out  WORD_SIZE  head instruction.
- if_pc  out  WORD_SIZE  PC of head instruction.

Behaviour:
- State: fetch_pc; resp_pending flag plus resp_pc; resp_squash flag; FIFO (rd/wr pointers, count 0..FIFO_DEPTH).
- Reset (reset_n low at posedge):
  - fetch_pc=RESET_PC; FIFO empty; resp_pending=0.
  - Outputs: i_readM=0, i_address=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
  - No issue while reset_n is low; Memory loads its image during that time.
- Issue condition (combinational):
  - issue = !redirect && !halt && (count + resp_pending) < FIFO_DEPTH.
  - Credit is conservative and ignores a same-cycle pop, so overflow is impossible.
- Bus drive:
  - i_readM = issue || resp_pending.
  - i_address = fetch_pc.
  - A read triggered only to hold the bus driven is harmless; its data is ignored.
- On issue: resp_pending<=1, resp_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^16; 16'hFFFF wraps to 0). Otherwise resp_pending<=0.
- Response: in the cycle after an issue, i_data is valid. If !resp_squash && !redirect, {resp_pc, i_data} is pushed at the closing edge.
- Pop: if_valid && id_ready pops at the edge. Push and pop in the same cycle leave count unchanged, and are legal at full or empty.
- Head outputs:
  - if_valid = (count != 0).
  - if_instr/if_pc = head entry when count != 0, else 0.
  - No bypass from i_data to outputs.
- Redirect (cycle N):
  - FIFO cleared and fetch_pc<=redirect_pc at the edge.
  - Any response arriving in cycle N is dropped; no issue in cycle N.
  - A pop coincident with redirect is discarded (redirect wins).
  - Timing: issue redirect_pc in N+1, push at end of N+2, if_valid in N+3.
- Redirect while halt: fetch_pc updates; issue waits for halt=0.
- Halt: blocks new issues only; an in-flight response still completes and pushes; FIFO drains normally.
- Throughput: 1 instruction/cycle in steady state with id_ready=1.
- Reset mid-operation: all state returns to reset values at the next edge; in-flight data is lost.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds out ports fetch_cnt[15:0] and flush_cnt[15:0], both reset to 0.
  - fetch_cnt increments once per pop; flush_cnt increments once per redirect cycle.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, Memory[0]=16'h9023, id_ready=1: issue addr 0 in cycle 0; if_valid=1 in cycle 2 with if_instr=9023, if_pc=0; then pc 1,2,3 on consecutive cycles.
- id_ready=0 after reset: exactly 4 entries fill with pcs 0..3; no issue beyond addr 3 (i_readM=0 once full); raise id_ready: pcs 0,1,2,3,4 delivered in order, nothing skipped or duplicated.
- redirect=1, redirect_pc=16'h23 while a response is pending and 2 entries are buffered: if_valid=0 next cycle; i_address=23 next cycle; first valid has if_pc=23, if_instr=16'h6000 three cycles after redirect; no stale pcs appear.
- Behavioural memory model, redirect_pc=16'hFFFF: delivered pcs FFFF, 0000, 0001.
- halt=1 with one request in flight: that entry is pushed; no further i_address advance; halt=0 resumes at the next sequential PC.
- reset_n=0 mid-stream with FIFO full: after one edge, if_valid=0, i_readM=0, i_address=RESET_PC; fetch restarts at 0 after release.
